// File: rtl/dsp_pkg.sv
// Shared DSP definitions: data width, 4-ASK slice codes, meter FSM states
// and a saturation helper used by the MER meter datapath.
package dsp_pkg;

    localparam int unsigned DATA_W = 18;          // 1s17 sample / metric width
    localparam int unsigned LVL_W  = DATA_W + 2;  // holds +-3r/2 for any r
    localparam int unsigned DIFF_W = DATA_W + 3;  // dec_var - level without wrap

    typedef logic [1:0] slc_t;

    localparam slc_t SLC_M3 = 2'b00;
    localparam slc_t SLC_M1 = 2'b01;
    localparam slc_t SLC_P1 = 2'b10;
    localparam slc_t SLC_P3 = 2'b11;

    typedef enum logic {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } meter_state_t;

    // Clamp a DIFF_W signed value into the DATA_W signed range.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [DIFF_W-1:0] x);
        if ((&x[DIFF_W-1:DATA_W-1]) || !(|x[DIFF_W-1:DATA_W-1])) begin
            return x[DATA_W-1:0];
        end else if (x[DIFF_W-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/ask4_slicer.sv
// 4-ASK slicer and level reconstruction (purely combinational).
// Ports:
//   dec_var  - decision variable, signed 1s17
//   ref_lvl  - reference level r, signed 1s17
//   slice_c  - decided symbol code (SLC_M3..SLC_P3)
//   level_c  - reconstructed level: -3h, -h, +h, +3h with h = r >>> 1
module ask4_slicer
    import dsp_pkg::*;
(
    input  logic signed [DATA_W-1:0] dec_var,
    input  logic signed [DATA_W-1:0] ref_lvl,
    output slc_t                     slice_c,
    output logic signed [LVL_W-1:0]  level_c
);

    logic signed [LVL_W-1:0] dv_w;
    logic signed [LVL_W-1:0] ref_w;
    logic signed [LVL_W-1:0] half;
    logic signed [LVL_W-1:0] three_half;

    // Thresholds at -r, 0, +r; each region maps to one reconstructed level.
    always_comb begin
        dv_w       = LVL_W'(dec_var);
        ref_w      = LVL_W'(ref_lvl);
        half       = ref_w >>> 1;
        three_half = half + (half <<< 1);
        slice_c    = SLC_M3;
        level_c    = -three_half;
        if (dv_w < -ref_w) begin
            slice_c = SLC_M3;
            level_c = -three_half;
        end else if (dv_w < LVL_W'(0)) begin
            slice_c = SLC_M1;
            level_c = -half;
        end else if (dv_w < ref_w) begin
            slice_c = SLC_P1;
            level_c = half;
        end else begin
            slice_c = SLC_P3;
            level_c = three_half;
        end
    end

endmodule

// File: rtl/mer_meter.sv
// MER meter for a 4-ASK receiver: picks the symbol-phase sample from a
// 4-deep delay line, slices it, and over windows of 2^ACC_LOG2 symbols
// averages |dec_var| (new reference level) and the squared decision error.
// Optional feature macro: MER_METER_ERR_MEAN_EN adds the err_mean output.
// Ports:
//   sys_clk, reset         - clock, synchronous active-high reset
//   sam_clk_en, sym_clk_en - sample / symbol strobes (sym on every 4th sample)
//   mf_in                  - matched-filter output, signed 1s17
//   phase_sel              - tap (0..3 samples of delay) loaded as dec_var
//   clr                    - restart the current measurement window
//   dec_var, slice, err    - decision variable, decided code, decision error
//   ref_lvl, err_sq_avg    - window-average |dec_var| and squared error
//   win_done, locked       - window-end pulse, first-window-completed flag
//   err_mean               - window-average error (only with the macro)
module mer_meter
    import dsp_pkg::*;
#(
    parameter int unsigned              ACC_LOG2 = 10,
    parameter logic signed [DATA_W-1:0] REF_INIT = 18'sd65536
)(
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     sym_clk_en,
    input  logic signed [DATA_W-1:0] mf_in,
    input  logic [1:0]               phase_sel,
    input  logic                     clr,
    output logic signed [DATA_W-1:0] dec_var,
    output slc_t                     slice,
    output logic signed [DATA_W-1:0] err,
    output logic signed [DATA_W-1:0] ref_lvl,
    output logic [DATA_W-1:0]        err_sq_avg,
    output logic                     win_done,
    output logic                     locked
`ifdef MER_METER_ERR_MEAN_EN
    ,
    output logic signed [DATA_W-1:0] err_mean
`endif
);

    localparam int unsigned ACC_W = DATA_W + ACC_LOG2;
    localparam int unsigned CNT_W = ACC_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ACC_LOG2) - 1);

    meter_state_t state_q;
    meter_state_t state_d;
    logic         locked_d;

    logic signed [DATA_W-1:0] dly1, dly2, dly3;
    logic signed [DATA_W-1:0] tap_c;
    logic                     acc_en;

    logic signed [LVL_W-1:0]    level_c;
    logic signed [DATA_W-1:0]   err_c;
    logic signed [2*DATA_W-1:0] prod_c;
    logic [DATA_W-1:0]          mag_c;
    logic [DATA_W-1:0]          sq_c;

    logic [ACC_W-1:0] mag_acc, sq_acc;
    logic [ACC_W-1:0] mag_sum_c, sq_sum_c, mag_avg_c;
    logic [CNT_W-1:0] cnt;
    logic             win_end_c;
    logic signed [DATA_W-1:0] ref_new_c;
    logic [DATA_W-1:0]        sq_avg_new_c;

    // Tap 0 is the live input; taps 1..3 are the registered history.
    always_comb begin
        tap_c = mf_in;
        case (phase_sel)
            2'd0:    tap_c = mf_in;
            2'd1:    tap_c = dly1;
            2'd2:    tap_c = dly2;
            default: tap_c = dly3;
        endcase
    end

    ask4_slicer u_slicer (
        .dec_var (dec_var),
        .ref_lvl (ref_lvl),
        .slice_c (slice),
        .level_c (level_c)
    );

    // Per-symbol error, magnitude and squared-error contributions.
    always_comb begin
        err_c  = sat_data(DIFF_W'(dec_var) - DIFF_W'(level_c));
        prod_c = err_c * err_c;
        sq_c   = DATA_W'(prod_c >> (DATA_W - 1));
        // Two's-complement negate also yields 2^17 correctly for the most negative input.
        mag_c  = dec_var[DATA_W-1] ? DATA_W'(-dec_var) : DATA_W'(dec_var);
    end

    // Window sums including the current symbol, and the averages taken from them.
    always_comb begin
        mag_sum_c = mag_acc + ACC_W'(mag_c);
        sq_sum_c  = sq_acc + ACC_W'(sq_c);
        mag_avg_c = mag_sum_c >> ACC_LOG2;
        win_end_c = acc_en && !clr && (cnt == CNT_LAST);
        if (|mag_avg_c[ACC_W-1:DATA_W-1]) begin
            ref_new_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            ref_new_c = DATA_W'(mag_avg_c);
        end
        sq_avg_new_c = DATA_W'(sq_sum_c >> ACC_LOG2);
    end

    // Acquisition FSM: leaves ACQ on the first completed window.
    always_comb begin
        state_d  = state_q;
        locked_d = 1'b0;
        case (state_q)
            ST_ACQ:   if (win_end_c) state_d = ST_TRACK;
            ST_TRACK: state_d = ST_TRACK;
            default:  state_d = ST_ACQ;
        endcase
        locked_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_ACQ;
            locked  <= 1'b0;
        end else begin
            state_q <= state_d;
            locked  <= locked_d;
        end
    end

    // Delay line, decision variable and error pipeline.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            dly1    <= '0;
            dly2    <= '0;
            dly3    <= '0;
            dec_var <= '0;
            acc_en  <= 1'b0;
            err     <= '0;
        end else begin
            if (sam_clk_en) begin
                dly1 <= mf_in;
                dly2 <= dly1;
                dly3 <= dly2;
            end
            if (sym_clk_en) begin
                dec_var <= tap_c;
            end
            acc_en <= sym_clk_en;
            if (acc_en) begin
                err <= err_c;
            end
        end
    end

    // Window accumulators; clr takes priority over a coinciding symbol.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            mag_acc    <= '0;
            sq_acc     <= '0;
            cnt        <= '0;
            ref_lvl    <= REF_INIT;
            err_sq_avg <= '0;
            win_done   <= 1'b0;
        end else begin
            win_done <= win_end_c;
            if (clr) begin
                mag_acc <= '0;
                sq_acc  <= '0;
                cnt     <= '0;
            end else if (acc_en) begin
                if (cnt == CNT_LAST) begin
                    mag_acc    <= '0;
                    sq_acc     <= '0;
                    cnt        <= '0;
                    ref_lvl    <= ref_new_c;
                    err_sq_avg <= sq_avg_new_c;
                end else begin
                    mag_acc <= mag_sum_c;
                    sq_acc  <= sq_sum_c;
                    cnt     <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef MER_METER_ERR_MEAN_EN
    logic signed [ACC_W-1:0] em_acc;
    logic signed [ACC_W:0]   em_wide_c;
    logic signed [ACC_W-1:0] em_sum_c;

    // Saturating signed error sum; mean is its arithmetic shift.
    always_comb begin
        em_wide_c = (ACC_W+1)'(em_acc) + (ACC_W+1)'(err_c);
        if (em_wide_c[ACC_W] != em_wide_c[ACC_W-1]) begin
            em_sum_c = {em_wide_c[ACC_W], {(ACC_W-1){~em_wide_c[ACC_W]}}};
        end else begin
            em_sum_c = em_wide_c[ACC_W-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            em_acc   <= '0;
            err_mean <= '0;
        end else if (clr) begin
            em_acc <= '0;
        end else if (acc_en) begin
            if (cnt == CNT_LAST) begin
                em_acc   <= '0;
                err_mean <= DATA_W'(em_sum_c >>> ACC_LOG2);
            end else begin
                em_acc <= em_sum_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mer_meter.sv
// Self-checking bench for mer_meter (ACC_LOG2 = 2): directed scenarios plus
// randomized samples, phases, gaps, clr and reset against a symbol-level model.
`timescale 1ns/1ps
module tb_mer_meter;
    import dsp_pkg::*;

    localparam int unsigned ACC_LOG2 = 2;
    localparam int WIN = 4;

    logic sys_clk = 1'b0;
    logic reset, sam_clk_en, sym_clk_en, clr;
    logic signed [17:0] mf_in;
    logic [1:0] phase_sel;
    logic signed [17:0] dec_var, err, ref_lvl;
    slc_t slice;
    logic [17:0] err_sq_avg;
    logic win_done, locked;
`ifdef MER_METER_ERR_MEAN_EN
    logic signed [17:0] err_mean;
`endif

    always #5 sys_clk = ~sys_clk;

    mer_meter #(.ACC_LOG2(ACC_LOG2), .REF_INIT(18'sd65536)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .mf_in      (mf_in),
        .phase_sel  (phase_sel),
        .clr        (clr),
        .dec_var    (dec_var),
        .slice      (slice),
        .err        (err),
        .ref_lvl    (ref_lvl),
        .err_sq_avg (err_sq_avg),
        .win_done   (win_done),
        .locked     (locked)
`ifdef MER_METER_ERR_MEAN_EN
        ,
        .err_mean   (err_mean)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_win = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    // Symbol-level reference model state.
    longint prev[3];
    longint m_dec, m_err, m_ref, m_sqavg, m_mean;
    bit     m_locked, m_done, pend_valid, clr_carry;
    longint pend_dv;
    longint win_mag[$], win_sq[$], win_err[$];

    function automatic longint sat18(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int code_of(input longint dv, input longint r);
        if (dv < -r) return 0;
        if (dv < 0) return 1;
        if (dv < r) return 2;
        return 3;
    endfunction

    function automatic longint level_of(input int code, input longint r);
        longint h;
        h = r >>> 1;
        case (code)
            0: return -3 * h;
            1: return -h;
            2: return h;
            default: return 3 * h;
        endcase
    endfunction

    task automatic clear_window();
        win_mag.delete();
        win_sq.delete();
        win_err.delete();
    endtask

    task automatic model_reset();
        prev = '{0, 0, 0};
        m_dec = 0; m_err = 0; m_ref = 65536; m_sqavg = 0; m_mean = 0;
        m_locked = 0; pend_valid = 0;
        clear_window();
    endtask

    task automatic close_window();
        longint sm, sq, se;
        sm = 0; sq = 0; se = 0;
        for (int i = 0; i < WIN; i++) begin
            sm += win_mag[i];
            sq += win_sq[i];
            se += win_err[i];
        end
        m_ref = (sm / WIN > 131071) ? 131071 : sm / WIN;
        m_sqavg = sq / WIN;
        m_mean = se >>> ACC_LOG2;
        m_done = 1;
        m_locked = 1;
        clear_window();
    endtask

    // One clock: drive, advance the model, compare every output.
    task automatic step(input longint x, input bit sam, input bit sym, input bit c, input bit rst);
        longint e;
        mf_in = 18'(x); sam_clk_en = sam; sym_clk_en = sym; clr = c; reset = rst;
        @(posedge sys_clk);
        #1;
        m_done = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (pend_valid) begin
                e = sat18(pend_dv - level_of(code_of(pend_dv, m_ref), m_ref));
                m_err = e;
                if (!c) begin
                    win_mag.push_back(pend_dv < 0 ? -pend_dv : pend_dv);
                    win_sq.push_back((e * e) >>> 17);
                    win_err.push_back(e);
                    if (win_mag.size() == WIN) close_window();
                end
            end
            if (c) clear_window();
            pend_valid = 0;
            if (sym) begin
                m_dec = (phase_sel == 2'd0) ? x : prev[phase_sel - 1];
                pend_valid = 1;
                pend_dv = m_dec;
            end
            if (sam) begin
                prev[2] = prev[1]; prev[1] = prev[0]; prev[0] = x;
            end
        end
        if (win_done) n_win++;
        check_val("dec_var", dec_var, m_dec);
        check_val("slice", slice, code_of(m_dec, m_ref));
        check_val("err", err, m_err);
        check_val("ref_lvl", ref_lvl, m_ref);
        check_val("err_sq_avg", err_sq_avg, m_sqavg);
        check_val("win_done", win_done, m_done);
        check_val("locked", locked, m_locked);
`ifdef MER_METER_ERR_MEAN_EN
        check_val("err_mean", err_mean, m_mean);
`endif
    endtask

    task automatic send_symbol(input longint a, input longint b, input longint c, input longint d,
                               input bit with_clr, input bit gaps);
        longint s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                step(0, 1'b0, 1'b0, clr_carry, 1'b0);
                clr_carry = 0;
            end
            step(s[i], 1'b1, i == 3, clr_carry || (i == 3 && with_clr), 1'b0);
            clr_carry = 0;
        end
        clr_carry = with_clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1'b0, 1'b0, clr_carry, 1'b0);
            clr_carry = 0;
        end
    endtask

    task automatic do_reset();
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        clr_carry = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic signed [17:0] rx [4];
        mf_in = '0; sam_clk_en = 0; sym_clk_en = 0; clr = 0; reset = 1; phase_sel = 2'd0;
        clr_carry = 0;
        model_reset();
        do_reset();
        do_reset();
        check_val("rst_ref", ref_lvl, 65536);
        check_val("rst_locked", locked, 0);
        check_val("rst_sq", err_sq_avg, 0);

        // Constant +0.25: first window sets r = 0.25, second sees err = -0.125.
        for (int k = 0; k < 4; k++) send_symbol(32768, 32768, 32768, 32768, 0, 0);
        check_val("w1_prelock", locked, 0);
        idle(1);
        check_val("w1_done", win_done, 1);
        check_val("w1_ref", ref_lvl, 32768);
        check_val("w1_locked", locked, 1);
        send_symbol(32768, 32768, 32768, 32768, 0, 0);
        check_val("w2_slice", slice, 3);
        for (int k = 0; k < 3; k++) send_symbol(32768, 32768, 32768, 32768, 0, 0);
        idle(1);
        check_val("w2_err", err, -16384);
        check_val("w2_sq", err_sq_avg, 2048);
        check_val("w2_done", win_done, 1);
`ifdef MER_METER_ERR_MEAN_EN
        check_val("w2_mean", err_mean, -16384);
`endif

        // Phase selection.
        do_reset();
        phase_sel = 2'd3;
        send_symbol(0, 0, 0, 40000, 0, 0);
        check_val("ph3_dec", dec_var, 0);
        phase_sel = 2'd0;
        send_symbol(0, 0, 0, 40000, 0, 0);
        check_val("ph0_dec", dec_var, 40000);
        idle(1);

        // Full-scale negative decision.
        do_reset();
        send_symbol(0, 0, 0, -131072, 0, 0);
        check_val("neg_slice", slice, 0);
        idle(1);
        check_val("neg_err", err, -32768);

        // clr on the third symbol restarts the window.
        do_reset();
        send_symbol(20000, 20000, 20000, 20000, 0, 0);
        send_symbol(20000, 20000, 20000, 20000, 0, 0);
        send_symbol(20000, 20000, 20000, 20000, 1, 0);
        w0 = n_win;
        for (int k = 0; k < 3; k++) send_symbol(20000, 20000, 20000, 20000, 0, 0);
        idle(1);
        check_val("clr_nowin", n_win - w0, 0);
        check_val("clr_ref", ref_lvl, 65536);
        send_symbol(20000, 20000, 20000, 20000, 0, 0);
        idle(1);
        check_val("clr_win", n_win - w0, 1);

        // Reset mid-window after locking.
        do_reset();
        for (int k = 0; k < 4; k++) send_symbol(32768, 32768, 32768, 32768, 0, 0);
        send_symbol(1000, 1000, 1000, 1000, 0, 0);
        send_symbol(1000, 1000, 1000, 1000, 0, 0);
        do_reset();
        check_val("mid_rst_ref", ref_lvl, 65536);
        check_val("mid_rst_locked", locked, 0);
        w0 = n_win;
        for (int k = 0; k < 3; k++) send_symbol(50000, 50000, 50000, 50000, 0, 0);
        idle(1);
        check_val("mid_rst_nowin", n_win - w0, 0);
        send_symbol(50000, 50000, 50000, 50000, 0, 0);
        idle(1);
        check_val("mid_rst_win", n_win - w0, 1);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if ($urandom % 100 == 0) do_reset();
            if ($urandom % 4 == 0) phase_sel = 2'($urandom);
            for (int j = 0; j < 4; j++) begin
                rx[j] = 18'($urandom);
                if ($urandom % 3 == 0) rx[j] = rx[j] >>> 2;
            end
            send_symbol(rx[0], rx[1], rx[2], rx[3], ($urandom % 20) == 0, 1);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mer_meter.md
MER_METER -- requirements
Module: mer_meter

Interface
REQ-001 SHALL have parameter ACC_LOG2, default 10, meaning log2 of the number of symbols per measurement window.
REQ-002 SHALL have parameter REF_INIT, default 18'sd65536, meaning the initial ref_lvl (0.5 in 1s17).
REQ-003 SHALL have port sys_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sam_clk_en, input, 1 bit: sample-rate enable, 1 pulse per sample.
REQ-006 SHALL have port sym_clk_en, input, 1 bit: symbol-rate enable; coincides with every 4th sam_clk_en.
REQ-007 SHALL have port mf_in, input, 18 bits signed 1s17: matched-filter output.
REQ-008 SHALL have port phase_sel, input, 2 bits: sample-phase delay, 0..3 samples.
REQ-009 SHALL have port clr, input, 1 bit: restart the current window.
REQ-010 SHALL have port dec_var, output, 18 bits signed: decision variable.
REQ-011 SHALL have port slice, output, 2 bits: decided 4-ASK symbol.
REQ-012 SHALL have port err, output, 18 bits signed: decision error.
REQ-013 SHALL have port ref_lvl, output, 18 bits signed: average |dec_var|.
REQ-014 SHALL have port err_sq_avg, output, 18 bits unsigned 0u18: mean squared error.
REQ-015 SHALL have port win_done, output, 1 bit: one-cycle pulse at window end.
REQ-016 SHALL have port locked, output, 1 bit: high once the first window has completed.

Function
REQ-017 SHALL shift mf_in into a 4-deep delay line on each sam_clk_en; tap 0 is the undelayed mf_in.
REQ-018 SHALL load dec_var with tap[phase_sel] on sym_clk_en; dec_var is valid the cycle after.
REQ-019 SHALL slice dec_var combinationally against thresholds -ref_lvl, 0 and +ref_lvl: below -ref_lvl gives 00; -ref_lvl up to but not including 0 gives 01; 0 up to but not including +ref_lvl gives 10; +ref_lvl and above gives 11.
REQ-020 SHALL map slice codes to reconstructed levels -3r/2, -r/2, +r/2 and +3r/2, where r = ref_lvl and r/2 is an arithmetic shift.
REQ-021 SHALL register err = dec_var - level, saturated to 18 bits, one cycle after dec_var updates.
REQ-022 SHALL, per symbol, add |dec_var| to an (18+ACC_LOG2)-bit magnitude accumulator and err*err bits [34:17] to an (18+ACC_LOG2)-bit square accumulator, in the cycle err is registered.
REQ-023 SHALL count accumulated symbols; after the 2^ACC_LOG2-th addition, ref_lvl <= mag_acc>>ACC_LOG2 and err_sq_avg <= sq_acc>>ACC_LOG2.
REQ-024 SHALL, in that same window-end cycle, pulse win_done for one cycle, zero both accumulators and the counter, and start the new window with no symbol lost.
REQ-025 SHALL implement FSM ACQ->TRACK: ACQ from reset with ref_lvl=REF_INIT and locked=0; first win_done moves to TRACK and sets locked=1; TRACK holds until reset.
REQ-026 SHALL, when clr and a symbol accumulation coincide, let clr win: the symbol is discarded, accumulators and counter are zeroed, and ref_lvl, err_sq_avg and the state are held.
REQ-027 SHALL apply a phase_sel change on the next sym_clk_en only; the window is not cleared.

Reset
REQ-028 SHALL, on reset, zero the delay line, dec_var, err, accumulators, counter and err_sq_avg; set ref_lvl=REF_INIT, win_done=0, locked=0 and state=ACQ. Reset mid-window discards all partial sums.

Configuration
REQ-029 SHALL, with macro MER_METER_ERR_MEAN_EN defined, add output err_mean (18 bits signed) = saturated signed sum of err over the window >>ACC_LOG2, updated at win_done and reset to 0; without the macro, the port and accumulator SHALL be absent.

Structure
REQ-030 SHALL take slice-code constants (SLC_M3, SLC_M1, SLC_P1, SLC_P3), data width 18 and the FSM state typedef from the shared package dsp_pkg.
REQ-031 SHALL place the slicer and level reconstruction in one combinational sub-module, ask4_slicer.

Verification
REQ-032 SHALL cover: ACC_LOG2=2, mf_in constant +32768 at phase 0 -> after 4 symbols ref_lvl=32768, slice=11, err=-16384, err_sq_avg=2048, win_done pulse, locked=1.
REQ-033 SHALL cover: mf_in sequence 0,0,0,+40000 repeated with sym_clk_en on the 4th sample -> phase_sel=3 gives dec_var=0 and phase_sel=0 gives dec_var=+40000.
REQ-034 SHALL cover: clr asserted with sym_clk_en in the window's 3rd symbol -> no win_done until 4 further symbols; ref_lvl is held.
REQ-035 SHALL cover: reset asserted mid-window after 2 symbols -> the next cycle shows ref_lvl=65536, locked=0, and a full new window is needed for win_done.
REQ-036 SHALL cover: dec_var=-131072 with ref_lvl=65536 -> slice=00, err=-131072-(-98304)=-32768, no overflow.
REQ-037 SHALL cover: with MER_METER_ERR_MEAN_EN defined, constant err=-16384 -> err_mean=-16384 at win_done.
